// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle processor: fetch FSM states,
// main opcodes and the default reset vector.
package cpu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned OPCODE_W  = 6;
    localparam int unsigned IMM_W     = 16;
    localparam int unsigned JIDX_W    = 26;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        EXEC,
        HALTED
    } fetch_state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    // Primary opcode field of an instruction word.
    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [XLEN-1:0] word);
        return word[XLEN-1 -: OPCODE_W];
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
// All additions wrap modulo 2^32.
module pc_next_logic
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instr,
    input  logic            jump,
    input  logic            branch_ctrl,
    input  logic            alu_zero,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4
);

    localparam int unsigned SEXT_W = XLEN - IMM_W - 2;

    logic [XLEN-1:0] br_offset;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jmp_target;
    logic            unused_opcode;

    // Opcode bits are decoded by the control unit, not here.
    assign unused_opcode = &{1'b0, instr[XLEN-1 -: OPCODE_W]};

    always_comb begin
        pc_plus4   = pc + 32'd4;
        br_offset  = {{SEXT_W{instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
        br_target  = pc_plus4 + br_offset;
        jmp_target = {pc_plus4[XLEN-1 -: 4], instr[JIDX_W-1:0], 2'b00};

        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jmp_target;
        end else if (branch_ctrl && alu_zero) begin
            next_pc = br_target;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, req/gnt/rvalid fetch FSM and
// instruction register feeding the control unit and datapath.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [XLEN-1:0]     imem_rdata,
    output logic [XLEN-1:0]     instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic                instr_valid,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    input  logic                branch_ctrl,
    input  logic                alu_zero,
    input  logic                jump,
    input  logic                halt,
    output logic                halted
);

    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            imem_req_q, imem_req_d;
    logic            halted_q, halted_d;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_plus4_w;

    pc_next_logic u_pc_next (
        .pc          (pc_q),
        .instr       (instr_q),
        .jump        (jump),
        .branch_ctrl (branch_ctrl),
        .alu_zero    (alu_zero),
        .next_pc     (next_pc),
        .pc_plus4    (pc_plus4_w)
    );

    // Next state; registered outputs are decoded from the state being entered.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                pc_d    = next_pc;
                state_d = halt ? HALTED : REQ;
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase

        imem_req_d    = (state_d == REQ);
        instr_valid_d = (state_d == EXEC);
        halted_d      = (state_d == HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC_ALIGNED;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            halted_q      <= halted_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = get_opcode(instr_q);
    assign instr_valid = instr_valid_q;
    assign pc_plus4    = pc_plus4_w;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scripted memory responder with a
// scoreboard of fetched words checked when the stage reports EXEC.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_ctrl;
    logic        alu_zero;
    logic        jump;
    logic        halt;
    logic        halted;

    int   n_checks;
    int   n_pass;
    int   cyc;
    int   last_valid_cyc;
    exp_t sb[$];

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .branch_ctrl (branch_ctrl),
        .alu_zero    (alu_zero),
        .jump        (jump),
        .halt        (halt),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    // One instruction: wait for req at exp_addr, grant after gnt_dly cycles,
    // return data after rv_dly more, then drive EXEC-cycle control inputs.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                            input int gnt_dly, input int rv_dly, input bit stray,
                            input bit jmp, input bit br, input bit zero, input bit hlt,
                            input bit chk_gap);
        int          guard;
        logic [31:0] prev_instr;
        exp_t        e;
        guard = 0;
        while (imem_req !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (imem_req !== 1'b1) begin
            $display("FAIL req_timeout @%h: req never rose within %0d cycles", exp_addr, guard);
            return;
        end else n_pass++;
        n_checks++;
        if (imem_addr !== exp_addr) $display("FAIL fetch_addr: got %h expected %h", imem_addr, exp_addr);
        else n_pass++;
        prev_instr = instr;
        for (int i = 0; i < gnt_dly; i++) begin
            imem_gnt    = 1'b0;
            imem_rvalid = stray;
            imem_rdata  = ~data;
            @(negedge clk);
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr)
                $display("FAIL addr_held: req %b addr %h expected req 1 addr %h", imem_req, imem_addr, exp_addr);
            else n_pass++;
        end
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL req_drop_in_wait: got %b expected 0", imem_req);
        else n_pass++;
        if (stray) begin
            n_checks++;
            if (instr !== prev_instr) $display("FAIL stray_rvalid: instr %h expected %h", instr, prev_instr);
            else n_pass++;
        end
        for (int i = 0; i < rv_dly; i++) @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        sb.push_back('{word: data, addr: exp_addr});
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        n_checks++;
        if (instr_valid !== 1'b1) $display("FAIL exec_valid @%h: got %b expected 1", exp_addr, instr_valid);
        else n_pass++;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: no expected entry for %h", exp_addr);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (instr !== e.word) $display("FAIL instr: got %h expected %h", instr, e.word);
            else n_pass++;
            n_checks++;
            if (opcode !== e.word[31:26]) $display("FAIL opcode: got %h expected %h", opcode, e.word[31:26]);
            else n_pass++;
            n_checks++;
            if (pc !== e.addr) $display("FAIL pc: got %h expected %h", pc, e.addr);
            else n_pass++;
            n_checks++;
            if (pc_plus4 !== e.addr + 32'd4) $display("FAIL pc_plus4: got %h expected %h", pc_plus4, e.addr + 32'd4);
            else n_pass++;
        end
        if (chk_gap) begin
            n_checks++;
            if (cyc - last_valid_cyc != 3 + gnt_dly + rv_dly)
                $display("FAIL valid_spacing: got %0d cycles expected %0d", cyc - last_valid_cyc, 3 + gnt_dly + rv_dly);
            else n_pass++;
        end
        last_valid_cyc = cyc;
        jump        = jmp;
        branch_ctrl = br;
        alu_zero    = zero;
        halt        = hlt;
        @(negedge clk);
        jump        = 1'b0;
        branch_ctrl = 1'b0;
        alu_zero    = 1'b0;
        halt        = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0) $display("FAIL valid_one_cycle: got %b expected 0", instr_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (pc !== RST_PC || imem_addr !== RST_PC) $display("FAIL reset_pc: pc %h addr %h expected %h", pc, imem_addr, RST_PC);
        else n_pass++;
        n_checks++;
        if (pc_plus4 !== 32'h0040_0004) $display("FAIL reset_pc_plus4: got %h expected 00400004", pc_plus4);
        else n_pass++;
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0)
            $display("FAIL reset_flags: req %b valid %b halted %b expected 000", imem_req, instr_valid, halted);
        else n_pass++;
        n_checks++;
        if (instr !== 32'h0 || opcode !== 6'h0) $display("FAIL reset_instr: instr %h opcode %h expected 0", instr, opcode);
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL idle_cycle1_req: got %b expected 0", imem_req);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC)
            $display("FAIL first_req_cycle2: req %b addr %h expected 1 %h", imem_req, imem_addr, RST_PC);
        else n_pass++;
    endtask

    task automatic test_sequential();
        do_fetch(RST_PC, {OP_J, 26'h0}, 0, 0, 0, 1, 0, 0, 0, 0);
        do_fetch(32'h0, 32'h0022_1820, 0, 0, 0, 0, 0, 0, 0, 1);
        do_fetch(32'h4, 32'h8C22_0004, 0, 0, 0, 0, 0, 0, 0, 1);
        do_fetch(32'h8, 32'hAC22_0008, 0, 0, 0, 0, 0, 0, 0, 1);
        do_fetch(32'hC, 32'h0043_2022, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_branch();
        do_fetch(32'h10, 32'h1000_FFFE, 0, 0, 0, 0, 1, 1, 0, 1);
        do_fetch(32'hC,  32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 1);
        do_fetch(32'h10, 32'h1000_FFFE, 0, 0, 0, 0, 1, 0, 0, 1);
        do_fetch(32'h14, {OP_J, 26'h400}, 0, 0, 0, 1, 0, 0, 0, 1);
    endtask

    task automatic test_jump_over_branch();
        do_fetch(32'h1000, {OP_J, 26'h040}, 0, 0, 0, 1, 1, 1, 0, 1);
    endtask

    task automatic test_wait_states();
        do_fetch(32'h100, 32'h8C01_0010, 2, 3, 1, 0, 0, 0, 0, 1);
    endtask

    task automatic test_wrap_and_halt();
        do_fetch(32'h104, {OP_BEQ, 10'h0, 16'hFFBE}, 0, 0, 0, 0, 1, 1, 0, 1);
        do_fetch(32'h0, 32'h1000_FFFE, 0, 0, 0, 0, 1, 1, 0, 1);
        do_fetch(32'hFFFF_FFFC, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 1);
        do_fetch(32'h0, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0) $display("FAIL halt_entry: halted %b req %b expected 1 0", halted, imem_req);
        else n_pass++;
        begin
            bit saw_req;
            saw_req = 1'b0;
            for (int i = 0; i < 6; i++) begin
                imem_gnt    = 1'b1;
                imem_rvalid = 1'b1;
                @(negedge clk);
                if (imem_req !== 1'b0 || halted !== 1'b1) saw_req = 1'b1;
            end
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            n_checks++;
            if (saw_req) $display("FAIL halted_absorbing: req %b halted %b expected 0 1", imem_req, halted);
            else n_pass++;
        end
    endtask

    task automatic test_mid_wait_reset();
        int guard;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        guard = 0;
        while (imem_req !== 1'b1 && guard < 5) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC)
            $display("FAIL rst_restart_req: req %b addr %h expected 1 %h", imem_req, imem_addr, RST_PC);
        else n_pass++;
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_checks++;
        if (pc !== RST_PC || imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0)
            $display("FAIL mid_wait_reset: pc %h req %b valid %b halted %b expected %h 0 0 0", pc, imem_req, instr_valid, halted, RST_PC);
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL mid_wait_idle: req %b expected 0", imem_req);
        else n_pass++;
        @(negedge clk);
        do_fetch(RST_PC, 32'h8C03_0000, 0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004)
            $display("FAIL post_reset_seq: req %b addr %h expected 1 00400004", imem_req, imem_addr);
        else n_pass++;
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        last_valid_cyc = 0;
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        branch_ctrl    = 1'b0;
        alu_zero       = 1'b0;
        jump           = 1'b0;
        halt           = 1'b0;

        test_reset();
        test_sequential();
        test_branch();
        test_jump_over_branch();
        test_wait_states();
        test_wrap_and_halt();
        test_mid_wait_reset();

        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
